// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : clock_time_counter
// Purpose  : 24-hour BCD time-of-day counter (HH:MM:SS). Samples the 1 Hz
//            square wave from the clock divider in the clk_in domain, turns
//            each rising edge into one tick, and advances seconds, minutes
//            and hours. A three-state mode FSM (RUN / SET_HOUR / SET_MIN)
//            lets the user set the time from debounced button pulses.
// Ports    : clk_in      - system clock, all logic on its rising edge
//            rst_n       - asynchronous active-low reset
//            sec_clk     - 1 Hz square wave, asynchronous, treated as data
//            mode_pulse  - one-cycle pulse, advances the mode FSM
//            inc_pulse   - one-cycle pulse, increments the selected field
//            hour_bcd    - hours   {tens[7:4], units[3:0]}
//            min_bcd     - minutes {tens[7:4], units[3:0]}
//            sec_bcd     - seconds {tens[7:4], units[3:0]}
//            mode        - 0 RUN, 1 SET_HOUR, 2 SET_MIN
//            day_pulse   - one-cycle pulse after 23:59:59 -> 00:00:00
// Revision : 1.0 - initial release
// ============================================================================
module clock_time_counter #(
    parameter logic [7:0] INIT_HOUR = 8'h12,
    parameter logic [7:0] INIT_MIN  = 8'h00,
    parameter logic [7:0] INIT_SEC  = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       sec_clk,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    // Counts the first three edges after reset release. Until all three sync
    // stages hold post-reset samples, s3 still carries its reset zero and a
    // sec_clk that is already high would look like a rising edge.
    logic [1:0] r_warm;

    logic       w_tick;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic [7:0] w_hour_next;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;

    assign w_tick = r_s2 & ~r_s3 & (r_warm == 2'd3);
    assign mode   = r_state;

    // BCD successors of each field; full 8-bit compares on the wrap values
    // so an out-of-range digit can never be produced.
    always_comb begin
        w_sec_wrap  = (sec_bcd  == 8'h59);
        w_min_wrap  = (min_bcd  == 8'h59);
        w_hour_wrap = (hour_bcd == 8'h23);

        if (w_sec_wrap)
            w_sec_next = 8'h00;
        else if (sec_bcd[3:0] == 4'h9)
            w_sec_next = {sec_bcd[7:4] + 4'h1, 4'h0};
        else
            w_sec_next = {sec_bcd[7:4], sec_bcd[3:0] + 4'h1};

        if (w_min_wrap)
            w_min_next = 8'h00;
        else if (min_bcd[3:0] == 4'h9)
            w_min_next = {min_bcd[7:4] + 4'h1, 4'h0};
        else
            w_min_next = {min_bcd[7:4], min_bcd[3:0] + 4'h1};

        if (w_hour_wrap)
            w_hour_next = 8'h00;
        else if (hour_bcd[3:0] == 4'h9)
            w_hour_next = {hour_bcd[7:4] + 4'h1, 4'h0};
        else
            w_hour_next = {hour_bcd[7:4], hour_bcd[3:0] + 4'h1};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_warm    <= 2'd0;
            hour_bcd  <= INIT_HOUR;
            min_bcd   <= INIT_MIN;
            sec_bcd   <= INIT_SEC;
            day_pulse <= 1'b0;
        end else begin
            r_s1      <= sec_clk;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            day_pulse <= 1'b0;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;

            case (r_state)
                ST_RUN: begin
                    // A tick and a mode change in the same cycle both apply.
                    if (w_tick) begin
                        sec_bcd <= w_sec_next;
                        if (w_sec_wrap) begin
                            min_bcd <= w_min_next;
                            if (w_min_wrap) begin
                                hour_bcd <= w_hour_next;
                                if (w_hour_wrap)
                                    day_pulse <= 1'b1;
                            end
                        end
                    end
                    if (mode_pulse)
                        r_state <= ST_SET_HOUR;
                end
                ST_SET_HOUR: begin
                    if (mode_pulse)
                        r_state <= ST_SET_MIN;
                    else if (inc_pulse)
                        hour_bcd <= w_hour_next;
                end
                ST_SET_MIN: begin
                    // Leaving set mode restarts the minute from zero seconds.
                    if (mode_pulse) begin
                        r_state <= ST_RUN;
                        sec_bcd <= 8'h00;
                    end else if (inc_pulse) begin
                        min_bcd <= w_min_next;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
